// File: rtl/psimd_instr_issuer.sv
// Host-side front end for the PSIMD core: buffers host instructions, issues one per cycle,
// captures tagged core results and returns them in issue order under credit-based flow control.
module psimd_instr_issuer #(
  parameter int          IFIFO_DEPTH = 4,
  parameter int          RFIFO_DEPTH = 4,
  parameter int          RESULT_LAT  = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int          TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic [31:0]      core_instr,
  input  logic [63:0]      core_data,
  input  logic [3:0]       core_invalid,
  input  logic [3:0]       core_inexact,
  input  logic [3:0]       core_overflow,
  input  logic [3:0]       core_underflow,
  input  logic [3:0]       core_div_by_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [19:0]      res_flags,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  localparam int IF_AW  = $clog2(IFIFO_DEPTH);
  localparam int RF_AW  = $clog2(RFIFO_DEPTH);
  localparam int ENT_W  = 64 + 20 + TAG_W;
  localparam int LAT_CW = $clog2(RESULT_LAT + 1);
  localparam int SUM_W  = RF_AW + 3;

  // Instruction FIFO (pointers carry an extra wrap bit)
  logic [31:0]      if_mem [IFIFO_DEPTH];
  logic [IF_AW:0]   if_wr, if_rd, if_count;
  logic             if_full, if_empty, in_push;

  // Result FIFO
  logic [ENT_W-1:0] rf_mem [RFIFO_DEPTH];
  logic [RF_AW:0]   rf_wr, rf_rd, rf_count;
  logic             rf_full, rf_empty, rf_push, rf_pop;
  logic [ENT_W-1:0] rf_head;

  // Issue pipeline tracking
  logic [RESULT_LAT-1:0] vld_pipe;
  logic [TAG_W-1:0]      tag_pipe [RESULT_LAT];
  logic [TAG_W-1:0]      tag;
  logic [LAT_CW-1:0]     inflight;
  logic                  credit, issue;

  assign if_count = if_wr - if_rd;
  assign if_full  = (if_count == (IF_AW+1)'(IFIFO_DEPTH));
  assign if_empty = (if_wr == if_rd);
  assign in_ready = !if_full;
  assign in_push  = in_valid & in_ready;

  assign rf_count = rf_wr - rf_rd;
  assign rf_full  = (rf_count == (RF_AW+1)'(RFIFO_DEPTH));
  assign rf_empty = (rf_wr == rf_rd);
  assign rf_push  = vld_pipe[RESULT_LAT-1];
  assign rf_pop   = res_valid & res_ready;

  // Results already in flight reserve a result-FIFO slot, so a capture can never overflow it.
  assign inflight = LAT_CW'($countones(vld_pipe));
  assign credit   = (SUM_W'(rf_count) + SUM_W'(inflight)) < SUM_W'(RFIFO_DEPTH);
  assign issue    = !if_empty & credit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_wr      <= '0;
      if_rd      <= '0;
      rf_wr      <= '0;
      rf_rd      <= '0;
      vld_pipe   <= '0;
      tag        <= '0;
      core_instr <= NOP_INSTR;
    end else begin
      if (in_push) if_wr <= if_wr + 1'b1;
      if (issue) begin
        if_rd      <= if_rd + 1'b1;
        tag        <= tag + 1'b1;
        core_instr <= if_mem[if_rd[IF_AW-1:0]];
      end else begin
        core_instr <= NOP_INSTR;
      end
      for (int i = RESULT_LAT - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[0] <= issue;
      if (rf_push) rf_wr <= rf_wr + 1'b1;
      if (rf_pop)  rf_rd <= rf_rd + 1'b1;
    end
  end

  // NOTE: storage arrays and the tag pipe are not reset; validity lives entirely in the
  // reset pointers and vld_pipe, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (in_push) if_mem[if_wr[IF_AW-1:0]] <= in_instr;
    if (rf_push) rf_mem[rf_wr[RF_AW-1:0]] <= {core_data, core_invalid, core_inexact,
                                              core_overflow, core_underflow,
                                              core_div_by_zero, tag_pipe[RESULT_LAT-1]};
    for (int i = RESULT_LAT - 1; i > 0; i--) tag_pipe[i] <= tag_pipe[i-1];
    tag_pipe[0] <= tag;
  end

  // Outputs are forced to zero while empty so unwritten storage never leaks out.
  assign res_valid = !rf_empty;
  assign rf_head   = rf_mem[rf_rd[RF_AW-1:0]];
  assign {res_data, res_flags, res_tag} = res_valid ? rf_head : '0;

  assign busy = !if_empty | (inflight != '0) | !rf_empty;

  a_no_rf_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(rf_push && rf_full));

endmodule

// File: tb/tb_psimd_instr_issuer.sv
// Directed bench for psimd_instr_issuer with a combinational core stub and an in-order result scoreboard.
module tb_psimd_instr_issuer;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] core_instr;
  logic [63:0] core_data;
  logic [3:0]  core_invalid, core_inexact, core_overflow, core_underflow, core_div_by_zero;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic [19:0] res_flags;
  logic [3:0]  res_tag;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          issue_cnt = 0;
  int          recv_cnt  = 0;
  logic [3:0]  exp_tag = '0;
  logic [31:0] exp_q [$];
  logic        fixed_mode = 1'b1;
  logic        mon_en = 1'b0;

  psimd_instr_issuer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .core_instr       (core_instr),
    .core_data        (core_data),
    .core_invalid     (core_invalid),
    .core_inexact     (core_inexact),
    .core_overflow    (core_overflow),
    .core_underflow   (core_underflow),
    .core_div_by_zero (core_div_by_zero),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_flags        (res_flags),
    .res_tag          (res_tag),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Core stub: result identifies the instruction that produced it.
  always_comb begin
    core_data        = {core_instr, ~core_instr};
    core_invalid     = core_instr[19:16];
    core_inexact     = core_instr[15:12];
    core_overflow    = core_instr[11:8];
    core_underflow   = core_instr[7:4];
    core_div_by_zero = core_instr[3:0];
    if (fixed_mode) begin
      core_data        = 64'h1111_2222_3333_4444;
      core_invalid     = 4'b0000;
      core_inexact     = 4'b0000;
      core_overflow    = 4'b0010;
      core_underflow   = 4'b0000;
      core_div_by_zero = 4'b0000;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int n);
    return 32'hC000_0001 + 32'(n) * 32'h0001_9A3B;
  endfunction

  always @(negedge clk) if (core_instr !== NOP) issue_cnt++;

  // Scoreboard: the pop happens on the next rising edge, inputs are stable until then.
  always @(negedge clk) begin
    if (mon_en && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", 64'(res_tag), 64'hFFFF);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        check("res_data", res_data, {w, ~w});
        check("res_flags", 64'(res_flags), 64'(w[19:0]));
        check("res_tag", 64'(res_tag), 64'(exp_tag));
        exp_tag = exp_tag + 4'd1;
        recv_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_instr = w;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(w);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    check("drain_done", 64'(exp_q.size() == 0 && !busy), 64'd1);
  endtask

  initial begin
    int base_iss, base_rcv;

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_core_instr", 64'(core_instr), 64'(NOP));
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_flags", 64'(res_flags), 64'd0);
    check("rst_res_tag", 64'(res_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single instruction latency with fixed stub result
    in_valid = 1'b1;
    in_instr = 32'hA5A5_0001;
    tick();                               // edge A: accepted
    in_valid = 1'b0;
    check("t1_no_bypass", 64'(core_instr), 64'(NOP));
    tick();                               // A+1: issued
    check("t1_issue", 64'(core_instr), 64'hA5A5_0001);
    check("t1_not_yet_valid", 64'(res_valid), 64'd0);
    tick();                               // A+2: captured
    check("t1_res_valid", 64'(res_valid), 64'd1);
    check("t1_res_data", res_data, 64'h1111_2222_3333_4444);
    check("t1_res_flags", 64'(res_flags), 64'h0_0200);
    check("t1_res_tag", 64'(res_tag), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t1_popped", 64'(res_valid), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);
    check("t1_res_data_zero", res_data, 64'd0);

    fixed_mode = 1'b0;
    exp_tag    = 4'd1;
    mon_en     = 1'b1;
    res_ready  = 1'b1;

    // Four back-to-back instructions: issue on consecutive edges
    base_rcv = recv_cnt;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = mk(i);
      tick();
      exp_q.push_back(mk(i));
      if (i > 0) check("t2_b2b_issue", 64'(core_instr), 64'(mk(i - 1)));
    end
    in_valid = 1'b0;
    tick();
    check("t2_b2b_issue_last", 64'(core_instr), 64'(mk(3)));
    wait_drain();
    check("t2_recv", 64'(recv_cnt - base_rcv), 64'd4);
    check("t2_busy_low", 64'(busy), 64'd0);

    // Backpressure: 8 instructions with results blocked
    res_ready = 1'b0;
    base_iss  = issue_cnt;
    base_rcv  = recv_cnt;
    for (int i = 0; i < 8; i++) send(mk(10 + i));
    repeat (6) tick();
    check("t3_issued_4", 64'(issue_cnt - base_iss), 64'd4);
    check("t3_core_nop", 64'(core_instr), 64'(NOP));
    check("t3_in_ready_low", 64'(in_ready), 64'd0);
    check("t3_res_valid", 64'(res_valid), 64'd1);

    // Input held with the instruction FIFO full: no accept until a pop
    in_valid = 1'b1;
    in_instr = mk(99);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_full_ready", 64'(in_ready), 64'd0);
    end
    check("t4_still_4_issued", 64'(issue_cnt - base_iss), 64'd4);
    res_ready = 1'b1;
    send(mk(99));
    wait_drain();
    check("t4_recv", 64'(recv_cnt - base_rcv), 64'd9);
    check("t4_issued", 64'(issue_cnt - base_iss), 64'd9);

    // Reset with work buffered and in flight
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(200 + i));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_tag = '0;
    check("t6_res_valid", 64'(res_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_core_nop", 64'(core_instr), 64'(NOP));
    check("t6_in_ready", 64'(in_ready), 64'd1);
    res_ready = 1'b1;
    repeat (5) tick();
    check("t6_no_ghost", 64'(res_valid), 64'd0);

    // Tag wrap across 20 instructions, starting at tag 0 after reset
    base_rcv = recv_cnt;
    for (int i = 0; i < 20; i++) send(mk(300 + i));
    wait_drain();
    check("t5_recv", 64'(recv_cnt - base_rcv), 64'd20);
    check("t5_next_tag", 64'(exp_tag), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
